// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin scheduler sharing one 8-bit ripple adder among NREQ requesters.
// Operands are registered on grant; the sum is registered and returned tagged with the requester ID.
module adder8 (
    input  logic [7:0] inputA,
    input  logic [7:0] inputB,
    output logic [8:0] out
);
    logic [8:0] w_c;
    assign w_c[0] = 1'b0;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign out[i]     = inputA[i] ^ inputB[i] ^ w_c[i];
        assign w_c[i + 1] = (inputA[i] & inputB[i]) | (w_c[i] & (inputA[i] ^ inputB[i]));
    end
    assign out[8] = w_c[8];
endmodule

module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [8:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic [15:0]       op_count
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         r_state, w_next;
    logic [IDW-1:0] r_rr_ptr, r_cur_id, r_rsp_id, w_win, w_ptr_nxt;
    logic [7:0]     r_op_a, r_op_b;
    logic [8:0]     r_rsp_sum, w_sum;
    logic [15:0]    r_op_count;
    logic           w_found, w_grant;

    // Scan downward so the candidate closest to rr_ptr is the last one written and wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    assign w_grant   = (r_state == IDLE) && w_found;
    assign w_ptr_nxt = IDW'((int'(w_win) + 1) % NREQ);
    assign req_ready = (rst_n && w_grant) ? (NREQ'(1) << w_win) : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_found ? CALC : IDLE;
            CALC:    w_next = RESP;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    adder8 u_adder (.inputA(r_op_a), .inputB(r_op_b), .out(w_sum));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_cur_id   <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rsp_sum  <= '0;
            r_rsp_id   <= '0;
            r_op_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_op_a   <= req_a[8*w_win +: 8];
                r_op_b   <= req_b[8*w_win +: 8];
                r_cur_id <= w_win;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == CALC) begin
                r_rsp_sum <= w_sum;
                r_rsp_id  <= r_cur_id;
            end
            if (r_state == RESP && rsp_ready)
                r_op_count <= r_op_count + 16'd1;
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: table-driven vectors plus corner sequences, responses checked via a scoreboard queue.
module tb_adder_share_arbiter;
    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] sum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [8:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [15:0] op_count;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;
    logic [8:0]  exp_sum [4];
    logic [10:0] sb [$];
    logic [10:0] mon_e;
    int          grants [$];
    vec_t        vecs [6];
    int          rr_exp [6] = '{0, 1, 2, 3, 0, 1};

    adder_share_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Grants push the requester's expected sum; response handshakes pop and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((req_valid & req_ready) != 4'b0) begin
                check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < 4; i++)
                    if (req_ready[i]) begin
                        sb.push_back({2'(i), exp_sum[i]});
                        grants.push_back(i);
                    end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = sb.pop_front();
                    check("rsp_sum", 32'(rsp_sum), 32'(mon_e[8:0]));
                    check("rsp_id", 32'(rsp_id), 32'(mon_e[10:9]));
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        exp_sum[id] = s;
    endtask

    task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
        @(posedge clk); #1;
        set_req(id, a, b, s);
        req_valid = 4'(1) << id;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(4'(1) << id));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("op_count", 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        vecs[0] = '{2, 8'h3C, 8'h05, 9'h041};
        vecs[1] = '{0, 8'hFF, 8'hFF, 9'h1FE};
        vecs[2] = '{1, 8'hFF, 8'h01, 9'h100};
        vecs[3] = '{3, 8'h00, 8'h00, 9'h000};
        vecs[4] = '{2, 8'h80, 8'h7F, 9'h0FF};
        vecs[5] = '{1, 8'hAA, 8'h56, 9'h100};

        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) single_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum);

        // Round robin with all requesters valid straight out of reset.
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_cnt = '0;
        sb.delete();
        grants.delete();
        set_req(0, 8'h10, 8'h01, 9'h011);
        set_req(1, 8'h20, 8'h02, 9'h022);
        set_req(2, 8'h30, 8'h03, 9'h033);
        set_req(3, 8'hF0, 8'h20, 9'h110);
        req_valid = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 40 && grants.size() < 6; c++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        check("rr_grants", 32'(grants.size()), 32'd6);
        for (int c = 0; c < 10 && sb.size() > 0; c++) @(negedge clk);
        check("rr_drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6 && k < grants.size(); k++) check("rr_order", 32'(grants[k]), 32'(rr_exp[k]));
        exp_cnt = exp_cnt + 16'd6;
        check("rr_op_count", 32'(op_count), 32'(exp_cnt));
        single_op(0, 8'h01, 8'h02, 9'h003);
        single_op(3, 8'hC8, 8'h64, 9'h12C);

        // Back-pressure: hold the response while another requester waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1, 8'h9A, 8'h77, 9'h111);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        set_req(2, 8'h12, 8'h34, 9'h046);
        req_valid = 4'b0100;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_sum", 32'(rsp_sum), 32'h111);
            check("bp_rsp_id", 32'(rsp_id), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        check("bp_op_count", 32'(op_count), 32'(exp_cnt));
        check("bp_next_ready", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("bp_once", 32'(op_count), 32'(exp_cnt));
        repeat (2) @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        check("bp_op_count2", 32'(op_count), 32'(exp_cnt));

        // Reset while in CALC discards the operation and rr_ptr.
        @(posedge clk); #1;
        set_req(2, 8'h11, 8'h22, 9'h033);
        req_valid = 4'b0100;
        @(negedge clk);
        check("mid_req_ready", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_req(1, 8'h40, 8'h40, 9'h080);
        set_req(3, 8'h01, 8'h01, 9'h002);
        req_valid = 4'b1010;
        sb.delete();
        exp_cnt = '0;
        repeat (3) begin
            @(negedge clk);
            check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
            check("mid_op_count", 32'(op_count), 32'd0);
            check("mid_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        check("post_rst_op_count", 32'(op_count), 32'(exp_cnt));
        check("post_rst_drain", 32'(sb.size()), 32'd0);

        // Counter wrap from a forced 0xFFFF.
        @(posedge clk); #1;
        force dut.r_op_count = 16'hFFFF;
        @(negedge clk);
        check("wrap_preload", 32'(op_count), 32'hFFFF);
        release dut.r_op_count;
        exp_cnt = 16'hFFFF;
        single_op(1, 8'h01, 8'hFE, 9'h0FF);
        check("wrap_zero", 32'(op_count), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin scheduler that shares a single instance of the team's gate-level 8-bit adder (ports inputA[7:0], inputB[7:0], out[8:0]) between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers the operands, drives the shared adder, and returns the registered 9-bit sum tagged with the requester ID on a single valid/ready response channel. It sits between the requesting datapaths and the adder netlist, so the adder is never driven by more than one source.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), width of requester ID
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i: requester i has an operand pair
- req_ready  out  NREQ  bit i: requester i granted; handshake when valid&ready
- req_a  in  NREQ*8  operand A of requester i at [8i+7:8i]
- req_b  in  NREQ*8  operand B of requester i at [8i+7:8i]
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_sum  out  9  A+B; bit 8 is carry-out
- rsp_id  out  IDW  ID of the requester this sum belongs to
- busy  out  1  high whenever state != IDLE
- op_count  out  16  completed responses; wraps modulo 2^16

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE: arbitrate among the asserted req_valid bits. Priority starts at rr_ptr and wraps upward (rr_ptr, rr_ptr+1, …, NREQ-1, 0, …).
  - req_ready is one-hot at the winner, or all-zero if no bit is valid. It is combinational from req_valid and rr_ptr and is only ever non-zero in IDLE.
  - On handshake: capture req_a/req_b of the winner into op_a/op_b and the winner ID into cur_id; set rr_ptr = (winner+1) mod NREQ; go to CALC.
- CALC: op_a/op_b drive the shared adder. At the next edge, register adder out[8:0] into rsp_sum and cur_id into rsp_id, then go to RESP.
- RESP: rsp_valid=1. rsp_sum and rsp_id are held stable until rsp_ready. On handshake: op_count += 1 (wraps 0xFFFF→0x0000), then go to IDLE.
- No other inputs feed the adder. op_a/op_b change only on a request handshake.
- Requester rule (bench checks it, block does not enforce): once req_valid[i] is asserted, it and the operands stay stable until the handshake. If req_valid drops before a grant, the block ignores that request.
- A non-power-of-two NREQ never selects a winner ID ≥ NREQ.
- Reset (async, any state): state=IDLE; rr_ptr=0; req_ready=0 while rst_n low; rsp_valid=0; rsp_sum=0; rsp_id=0; busy=0; op_count=0; op_a=op_b=0.
  - An in-flight operation is discarded and no response is produced for it.
  - After rst_n deasserts, the first grant may occur at the first clock edge.

## Timing
- The request handshake at edge N means the block leaves IDLE at N; rsp_valid rises after edge N+1, and the sum is visible in the cycle after N+1.
- With rsp_ready held high, the response handshake occurs at edge N+2 and the block is back in IDLE.
- The next request handshake is at N+3, so peak throughput is 1 operation per 3 cycles.
- Back-pressure: each cycle rsp_ready stays low extends RESP by one cycle. No request is granted during that time.
- busy = (state != IDLE). It is registered and rises the cycle after the grant.
- Simultaneous requests are served strictly round-robin. With all NREQ valid continuously, each requester receives exactly one grant per NREQ operations.
- Adder critical path: op_a/op_b registers → 8-bit ripple → rsp_sum register, one full cycle.

## Test plan
- Reset/single op: after reset, all outputs zero. Requester 2 sends A=0x3C, B=0x05 → req_ready=4'b0100 in the same cycle; rsp_valid after 2 edges with rsp_sum=0x041, rsp_id=2; op_count=1 after the handshake.
- Carry/boundaries: the pairs 0xFF+0xFF, 0xFF+0x01 and 0x00+0x00 produce rsp_sum 0x1FE, 0x100 and 0x000.
- Round-robin fairness: all 4 requesters valid continuously from reset → grant order 0,1,2,3,0,1 with the correct per-requester sums. A lone requester 3 after rr_ptr=1 is still granted immediately.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_sum and rsp_id are stable, req_ready stays 0 and busy stays 1. Releasing rsp_ready gives exactly one handshake and op_count increments once.
- Reset mid-operation: assert rst_n low during CALC → rsp_valid never rises for that op, op_count=0 and rr_ptr=0. The next grant goes to the lowest-index valid requester.
- Counter wrap: preload via 65536 ops (or a force) → op_count goes 0xFFFF→0x0000 on the next response handshake.
